// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the RISC-V data memory unit.
// Holds the load/store funct3 encodings and the controller state type.
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/data_memory_unit_if.sv
// Request/response bundle between the pipeline and the data memory.
// master: issues req_valid/mem_read/mem_write/funct3/addr/write_data,
// receives req_ready/resp_valid/read_data/fault. slave is the mirror.
interface data_memory_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        resp_valid;
    logic [31:0] read_data;
    logic        fault;

    modport master (
        output req_valid, mem_read, mem_write, funct3, addr, write_data,
        input  req_ready, resp_valid, read_data, fault
    );

    modport slave (
        input  req_valid, mem_read, mem_write, funct3, addr, write_data,
        output req_ready, resp_valid, read_data, fault
    );

endinterface

// File: rtl/mem_align.sv
// Combinational byte-lane logic: load extract/extend, store byte enables
// and replication, and the request fault check (funct3, alignment, range).
module mem_align
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic [31:0] word,
    output logic [31:0] load_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_data,
    output logic        fault
);

    logic [1:0]  lane;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic        bad_f3;
    logic        misalign;
    logic        out_of_range;

    assign lane  = addr[1:0];
    assign sel_b = word[{lane, 3'b000} +: 8];
    assign sel_h = word[{addr[1], 4'b0000} +: 16];

    // Any set bit above the word-index field lies beyond the array.
    assign out_of_range = |addr[31:ADDR_BITS+2];

    always_comb begin
        load_data  = '0;
        byte_en    = '0;
        store_data = write_data;
        bad_f3     = 1'b0;
        misalign   = 1'b0;
        case (funct3)
            F3_B: begin
                load_data  = {{24{sel_b[7]}}, sel_b};
                byte_en    = 4'b0001 << lane;
                store_data = {4{write_data[7:0]}};
            end
            F3_H: begin
                load_data  = {{16{sel_h[15]}}, sel_h};
                byte_en    = 4'b0011 << {addr[1], 1'b0};
                store_data = {2{write_data[15:0]}};
                misalign   = addr[0];
            end
            F3_W: begin
                load_data = word;
                byte_en   = 4'b1111;
                misalign  = |lane;
            end
            F3_BU: begin
                load_data = {24'b0, sel_b};
                bad_f3    = mem_write;
            end
            F3_HU: begin
                load_data = {16'b0, sel_h};
                misalign  = addr[0];
                bad_f3    = mem_write;
            end
            default: bad_f3 = 1'b1;
        endcase
    end

    // A NOP never faults; it only produces an empty response.
    assign fault = (mem_read | mem_write)
                 & (bad_f3 | misalign | out_of_range
                    | (mem_read & mem_write));

endmodule

// File: rtl/data_memory_unit.sv
// Byte-addressed RISC-V data memory: zeroes itself after reset, then serves
// one load/store per 3 cycles. Ports: clock, reset, bus (slave handshake).
module data_memory_unit
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic               clock,
    input  logic               reset,
    data_memory_unit_if.slave  bus
);

    localparam int ADDR_BITS = $clog2(DEPTH);

    state_t                 state;
    state_t                 state_nx;
    logic [ADDR_BITS-1:0]   init_cnt;
    logic                   init_last;

    logic                   r_read;
    logic                   r_write;
    logic [2:0]             r_f3;
    logic [31:0]            r_addr;
    logic [31:0]            r_wdata;

    logic [31:0]            mem [DEPTH];
    logic [ADDR_BITS-1:0]   idx;
    logic [31:0]            load_data;
    logic [3:0]             byte_en;
    logic [31:0]            store_data;
    logic                   flt;

    assign idx       = r_addr[ADDR_BITS+1:2];
    assign init_last = (init_cnt == ADDR_BITS'(DEPTH - 1));

    mem_align #(
        .ADDR_BITS (ADDR_BITS)
    ) u_align (
        .mem_read   (r_read),
        .mem_write  (r_write),
        .funct3     (r_f3),
        .addr       (r_addr),
        .write_data (r_wdata),
        .word       (mem[idx]),
        .load_data  (load_data),
        .byte_en    (byte_en),
        .store_data (store_data),
        .fault      (flt)
    );

    always_comb begin
        state_nx = state;
        case (state)
            INIT:    if (init_last) state_nx = IDLE;
            IDLE:    if (bus.req_valid) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = INIT;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= INIT;
            init_cnt      <= '0;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_f3          <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            bus.read_data <= '0;
            bus.fault     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
            if (state == IDLE && bus.req_valid) begin
                r_read  <= bus.mem_read;
                r_write <= bus.mem_write;
                r_f3    <= bus.funct3;
                r_addr  <= bus.addr;
                r_wdata <= bus.write_data;
            end
            if (state == ACCESS) begin
                bus.read_data <= (r_read && !flt) ? load_data : '0;
                bus.fault     <= flt;
            end
        end
    end

    // The array has no reset; INIT clears it. A reset landing in ACCESS
    // forces state to INIT first, so the pending store is dropped.
    always_ff @(posedge clock) begin
        if (state == INIT) begin
            mem[init_cnt] <= '0;
        end else if (state == ACCESS && r_write && !flt) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[idx][8*i +: 8] <= store_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// Randomized and directed bench for data_memory_unit against a byte-array
// reference model of the load/store and fault rules.
module tb_data_memory_unit;
    import riscv_mem_pkg::*;

    localparam int DEPTH = 256;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    data_memory_unit_if bus();

    data_memory_unit #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] mb [DEPTH*4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic zero_model();
        foreach (mb[i]) mb[i] = 8'h00;
    endtask

    task automatic model(input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd,
                         output logic flt, output logic [31:0] data);
        int size;
        logic [31:0] v;
        flt  = 1'b0;
        data = 32'h0;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        if (!(rd || wr)) return;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) flt = 1'b1;
        if (f3[2] && wr) flt = 1'b1;
        if (rd && wr) flt = 1'b1;
        if ((a % size) != 0) flt = 1'b1;
        if (a >= DEPTH * 4) flt = 1'b1;
        if (flt) return;
        if (wr) begin
            for (int i = 0; i < size; i++) mb[a + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = mb[a + i];
            if (!f3[2] && size < 4 && v[8*size-1])
                for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            data = v;
        end
    endtask

    task automatic wait_ready(input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clock);
            if (bus.req_ready) break;
        end
        chk("ready_wait", bus.req_ready, 1);
    endtask

    task automatic do_req(input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd,
                          output logic [31:0] rdata, output logic flt);
        logic ef;
        logic [31:0] ed;
        wait_ready(40);
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.write_data = wd;
        bus.req_valid  = 1'b1;
        model(rd, wr, f3, a, wd, ef, ed);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        chk("busy_ready", bus.req_ready, 0);
        chk("early_resp", bus.resp_valid, 0);
        @(negedge clock);
        chk("resp_valid", bus.resp_valid, 1);
        rdata = bus.read_data;
        flt   = bus.fault;
        chk("fault", flt, ef);
        chk("read_data", rdata, ed);
        @(negedge clock);
        chk("resp_drop", bus.resp_valid, 0);
        chk("ready_back", bus.req_ready, 1);
    endtask

    logic [31:0] d;
    logic        f;

    initial begin
        bus.req_valid  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.funct3     = 3'b0;
        bus.addr       = 32'h0;
        bus.write_data = 32'h0;
        zero_model();

        // Reset values and INIT duration
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_resp", bus.resp_valid, 0);
        chk("rst_rdata", bus.read_data, 0);
        chk("rst_fault", bus.fault, 0);
        reset = 1'b0;
        begin
            int k;
            k = 0;
            while (k < 2 * DEPTH) begin
                @(posedge clock);
                @(negedge clock);
                k++;
                if (bus.req_ready) break;
            end
            chk("init_cycles", k, DEPTH);
        end

        do_req(1, 0, F3_W, 32'h10, 32'h0, d, f);
        chk("lw_zero", d, 32'h0);
        chk("lw_zero_flt", f, 0);

        // Sub-word loads
        do_req(0, 1, F3_W, 32'h20, 32'h80F0_1234, d, f);
        do_req(1, 0, F3_B, 32'h20, 32'h0, d, f);
        chk("lb_20", d, 32'h0000_0034);
        do_req(1, 0, F3_B, 32'h21, 32'h0, d, f);
        chk("lb_21", d, 32'h0000_0012);
        do_req(1, 0, F3_BU, 32'h22, 32'h0, d, f);
        chk("lbu_22", d, 32'h0000_00F0);
        do_req(1, 0, F3_B, 32'h22, 32'h0, d, f);
        chk("lb_22", d, 32'hFFFF_FFF0);
        do_req(1, 0, F3_H, 32'h22, 32'h0, d, f);
        chk("lh_22", d, 32'hFFFF_80F0);

        // Byte store merges into existing word
        do_req(0, 1, F3_W, 32'h40, 32'h1122_3344, d, f);
        do_req(0, 1, F3_B, 32'h41, 32'h5555_55AB, d, f);
        do_req(1, 0, F3_W, 32'h40, 32'h0, d, f);
        chk("sb_merge", d, 32'h1122_AB44);

        // Faulting requests
        do_req(1, 0, F3_H, 32'h03, 32'h0, d, f);
        chk("lh_mis_flt", f, 1);
        chk("lh_mis_d", d, 0);
        do_req(0, 1, F3_W, 32'h22, 32'hFFFF_FFFF, d, f);
        chk("sw_mis_flt", f, 1);
        do_req(1, 0, F3_W, DEPTH * 4, 32'h0, d, f);
        chk("lw_oob_flt", f, 1);
        chk("lw_oob_d", d, 0);
        do_req(1, 0, 3'b011, 32'h20, 32'h0, d, f);
        chk("f3_011_flt", f, 1);
        chk("f3_011_d", d, 0);
        do_req(1, 1, F3_W, 32'h20, 32'h1234_5678, d, f);
        chk("rdwr_flt", f, 1);
        chk("rdwr_d", d, 0);
        do_req(1, 0, F3_W, 32'h20, 32'h0, d, f);
        chk("unchanged", d, 32'h80F0_1234);
        do_req(0, 0, F3_W, 32'h20, 32'h0, d, f);
        chk("nop_d", d, 0);
        chk("nop_flt", f, 0);

        // Back-to-back requests with req_valid held high
        for (int i = 0; i < 4; i++)
            do_req(0, 1, F3_W, 32'h100 + 4 * i, 32'hA000_0000 + i, d, f);
        begin
            logic [31:0] exp_q[$];
            int acc_q[$];
            int last_acc;
            int n_resp;
            int cyc;
            int i;
            logic ef;
            logic [31:0] ed;
            last_acc = 0;
            n_resp   = 0;
            cyc      = 0;
            i        = 0;
            for (int t = 0; t < 40 && n_resp < 4; t++) begin
                @(negedge clock);
                cyc++;
                if (bus.resp_valid) begin
                    n_resp++;
                    if (exp_q.size() == 0) begin
                        chk("b2b_spurious", 1, 0);
                    end else begin
                        chk("b2b_data", bus.read_data, exp_q.pop_front());
                        chk("b2b_latency", cyc - acc_q.pop_front(), 2);
                    end
                end
                if (i < 4) begin
                    bus.mem_read   = 1'b1;
                    bus.mem_write  = 1'b0;
                    bus.funct3     = F3_W;
                    bus.addr       = 32'h100 + 4 * i;
                    bus.req_valid  = 1'b1;
                    if (bus.req_ready) begin
                        if (i > 0) chk("b2b_spacing", cyc - last_acc, 3);
                        last_acc = cyc;
                        model(1, 0, F3_W, 32'h100 + 4 * i, 32'h0, ef, ed);
                        exp_q.push_back(ed);
                        acc_q.push_back(cyc);
                        i++;
                    end
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            bus.req_valid = 1'b0;
            chk("b2b_count", n_resp, 4);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            logic rd;
            logic wr;
            logic [2:0] f3;
            logic [31:0] a;
            int k;
            int r;
            k  = $urandom_range(0, 9);
            rd = (k == 1) || (k >= 2 && k <= 5);
            wr = (k == 1) || (k >= 6);
            f3 = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            if (r == 0) a = $urandom;
            else if (r == 1) a = DEPTH * 4 + $urandom_range(0, 15);
            else a = $urandom_range(0, 63);
            do_req(rd, wr, f3, a, $urandom, d, f);
        end

        // Reset while a store is in ACCESS
        wait_ready(40);
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b1;
        bus.funct3     = F3_W;
        bus.addr       = 32'h8;
        bus.write_data = 32'hDEAD_BEEF;
        bus.req_valid  = 1'b1;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("rst_no_resp", bus.resp_valid, 0);
        end
        reset = 1'b0;
        zero_model();
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 2 * DEPTH + 10; k++) begin
                @(negedge clock);
                if (bus.resp_valid) seen = 1;
                if (bus.req_ready) break;
            end
            chk("rst_init_resp", seen, 0);
            chk("rst_init_ready", bus.req_ready, 1);
        end
        do_req(1, 0, F3_W, 32'h8, 32'h0, d, f);
        chk("rst_dropped_sw", d, 32'h0);
        do_req(1, 0, F3_W, 32'h20, 32'h0, d, f);
        chk("rst_rezero", d, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Byte-addressed RISC-V data memory with a request/response handshake. It executes LB/LH/LW/LBU/LHU loads and SB/SH/SW stores against an internal word array, sign- or zero-extending load data. It sits directly upstream of the write-back select multiplexer and supplies its "data read from memory" input. The ALU result supplies the address, and register operand 2 supplies the store data.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, at least 4.
- ADDR_BITS, log2(DEPTH): word-index width; derived, never overridden.
- clock  in  1  single clock, rising edge.
- reset  in  1  reset, asynchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit accepts a request this cycle.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- funct3  in  3  RISC-V width/sign field.
- addr  in  32  byte address.
- write_data  in  32  store data; the low byte or half is used for SB/SH.
- resp_valid  out  1  one-cycle response strobe.
- read_data  out  32  extended load result; 0 for stores, NOPs and faults.
- fault  out  1  request rejected.

## Operation
- FSM states: INIT, IDLE, ACCESS, RESP.
  - INIT: writes 0 to word index init_cnt, then increments init_cnt.
  - INIT exits to IDLE after the write to word DEPTH-1.
  - IDLE: req_ready=1. On req_valid, captures mem_read, mem_write, funct3, addr and write_data, then goes to ACCESS.
  - ACCESS: performs the array read or byte-lane-masked write and registers read_data and fault, then goes to RESP.
  - RESP: resp_valid=1, then goes to IDLE.
- Loads:
  - Word index is addr[ADDR_BITS+1:2]; byte lane is addr[1:0].
  - LB/LH take the selected byte or halfword and sign-extend it from bit 7/15.
  - LBU/LHU zero-extend the selected byte or halfword.
  - LW returns the whole word.
- Stores: SB writes one lane, SH writes lanes {addr[1],0}+0..1, SW writes all four lanes. Unselected lanes are unchanged.
- A request faults, and then causes no array write and returns read_data=0, when any of these holds:
  - funct3 is 011, 110 or 111;
  - funct3 is 100 or 101 with mem_write set;
  - mem_read and mem_write are both 1;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - addr ≥ DEPTH*4.
- mem_read=mem_write=0 is a NOP: it still produces a response, with read_data=0 and fault=0.
- read_data and fault hold their value until the next ACCESS edge.

## Timing
- Reset values:
  - state=INIT, init_cnt=0;
  - req_ready=0, resp_valid=0;
  - read_data=0, fault=0.
- After reset deassertion, INIT lasts exactly DEPTH cycles; req_ready first rises in cycle DEPTH.
- For a request accepted at edge E0:
  - the array is accessed at edge E1;
  - resp_valid is high for the single cycle between E1 and E2;
  - req_ready returns high after E2.
- Latency is 2 cycles; throughput is one request per 3 cycles.
- req_valid is ignored outside IDLE.
- A load to the same word immediately after a store returns the stored data, because the store has committed at its own E1.
- Reset asserted mid-operation:
  - Asserted in ACCESS before E1: the pending write is dropped, and no response is issued.
  - Asserted during RESP: the strobe drops immediately.
  - In both cases the array is re-zeroed by INIT.
- Address arithmetic is unsigned 32-bit. Upper bits above ADDR_BITS+1 must be zero, otherwise the request faults.

## Structure
- Shared package riscv_mem_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - the state enum {INIT, IDLE, ACCESS, RESP}.
- Sub-module mem_align (combinational) holds all lane logic:
  - load extract and extension;
  - store byte-enable and data replication;
  - the misalignment check.
- The top level holds the FSM, init counter, array and request registers.

## Test plan
- Reset, then count cycles: req_ready=0 for exactly DEPTH cycles, then 1. An LW at addr 0x10 returns 0x00000000, fault=0.
- SW 0x80F0_1234 at 0x20, then LB at 0x20 → 0x00000034; LB at 0x21 → 0x00000012; LBU at 0x22 → 0x000000F0; LB at 0x22 → 0xFFFFFFF0; LH at 0x22 → 0xFFFF80F0.
- SB 0xAB at 0x41 over an existing word 0x11223344 → an LW at 0x40 returns 0x1122AB44.
- Each of LH at 0x03, SW at 0x22, LW at addr=DEPTH*4, funct3=011, and mem_read=mem_write=1 → resp_valid with fault=1 and read_data=0. A following LW confirms memory is unchanged.
- Hold req_valid high continuously for 4 LWs: resp_valid pulses once per 3 cycles, 2 cycles after each acceptance, in request order.
- Assert reset while in ACCESS of an SW 0xDEADBEEF at 0x8: no resp_valid. After INIT, an LW at 0x8 returns 0x00000000.
